// File: rtl/ic_tester_pkg.sv
// +------------------------------------------------------------------+
// | ic_tester_pkg: shared codes and packet layout for the IC tester  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package ic_tester_pkg;

  localparam logic [2:0] MODE_NOT = 3'b000;
  localparam logic [2:0] MODE_2IN = 3'b001;
  localparam logic [2:0] MODE_3IN = 3'b010;
  localparam logic [2:0] MODE_4IN = 3'b011;
  localparam logic [2:0] MODE_8IN = 3'b100;

  localparam logic [7:0] PKT_HEADER = 8'hA5;
  localparam int         PKT_LEN    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [7:0] build_status_byte(input logic [2:0] m,
                                                   input logic       p,
                                                   input logic       f);
    return {m, 3'b000, p, f};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// +------------------------------------------------------------------+
// | uart_tx_byte: 8N1 serialiser for one byte, chains back-to-back   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module uart_tx_byte
  import ic_tester_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       tx,
  output logic       byte_done
);

  localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_tx, w_tx_nxt;
  logic             w_bit_end;

  assign w_bit_end = (r_cnt == c_CNT_MAX);
  assign tx        = r_tx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    byte_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        w_tx_nxt  = 1'b1;
        if (byte_valid) begin
          w_state_nxt = ST_START;
          w_shift_nxt = byte_data;
          w_tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        // A byte offered on the final stop cycle starts with no idle gap
        if (w_bit_end) begin
          byte_done = 1'b1;
          w_cnt_nxt = '0;
          if (byte_valid) begin
            w_state_nxt = ST_START;
            w_shift_nxt = byte_data;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/result_uart_reporter.sv
// +------------------------------------------------------------------+
// | result_uart_reporter: frames tester verdicts into a 5-byte UART  |
// | packet (header, status, pass_vec, fail_vec, xor checksum)        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module result_uart_reporter
  import ic_tester_pkg::*;
#(
  parameter int         CLK_FREQ = 50000000,
  parameter int         BAUD     = 115200,
  parameter logic [7:0] HEADER   = PKT_HEADER
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       report_valid,
  output logic       report_ready,
  input  logic [2:0] mode,
  input  logic [5:0] pass_vec,
  input  logic [5:0] fail_vec,
  input  logic       pass,
  input  logic       fail,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [2:0] c_LAST_IDX = 3'(PKT_LEN - 1);

  logic       r_busy, r_done, r_overrun;
  logic [2:0] r_byte_idx;
  logic [7:0] r_b1, r_b2, r_b3, r_b4;
  logic       w_accept, w_byte_done, w_byte_valid;
  logic [7:0] w_b1, w_next_byte, w_byte_data;

  assign report_ready = !r_busy;
  assign busy         = r_busy;
  assign done         = r_done;
  assign overrun      = r_overrun;
  assign w_accept     = report_valid && !r_busy;
  assign w_b1         = build_status_byte(mode, pass, fail);

  always_comb begin
    case (r_byte_idx)
      3'd0:    w_next_byte = r_b1;
      3'd1:    w_next_byte = r_b2;
      3'd2:    w_next_byte = r_b3;
      default: w_next_byte = r_b4;
    endcase
  end

  // The header goes straight from the accept edge, so it bypasses the holding registers
  assign w_byte_valid = w_accept || (w_byte_done && (r_byte_idx != c_LAST_IDX));
  assign w_byte_data  = w_accept ? HEADER : w_next_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_byte_idx <= '0;
      r_b1       <= '0;
      r_b2       <= '0;
      r_b3       <= '0;
      r_b4       <= '0;
    end else begin
      r_done <= 1'b0;
      if (report_valid && r_busy) r_overrun <= 1'b1;
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_byte_idx <= '0;
        r_b1       <= w_b1;
        r_b2       <= {2'b00, pass_vec};
        r_b3       <= {2'b00, fail_vec};
        r_b4       <= HEADER ^ w_b1 ^ {2'b00, pass_vec} ^ {2'b00, fail_vec};
      end else if (w_byte_done) begin
        if (r_byte_idx == c_LAST_IDX) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_byte_idx <= r_byte_idx + 3'd1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_valid(w_byte_valid),
    .byte_data (w_byte_data),
    .tx        (tx),
    .byte_done (w_byte_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_result_uart_reporter.sv
// +------------------------------------------------------------------+
// | tb_result_uart_reporter: bench for result_uart_reporter          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_result_uart_reporter;
  import ic_tester_pkg::*;

  localparam int CPB     = 10;
  localparam int PKT_CYC = 50 * CPB;

  typedef struct {
    logic [2:0]      mode;
    logic            pass;
    logic            fail;
    logic [5:0]      pv;
    logic [5:0]      fv;
    logic [4:0][7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       report_valid, d_valid;
  logic [2:0] mode;
  logic [5:0] pass_vec, fail_vec;
  logic       pass, fail;
  logic       report_ready, tx, busy, done, overrun;
  logic       d_ready, d_tx, d_busy, d_done, d_overrun;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_ovr = 1'b0;

  always #5 clk = ~clk;

  result_uart_reporter #(.CLK_FREQ(1000), .BAUD(100), .HEADER(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .report_valid(report_valid), .report_ready(report_ready),
    .mode(mode), .pass_vec(pass_vec), .fail_vec(fail_vec), .pass(pass), .fail(fail),
    .tx(tx), .busy(busy), .done(done), .overrun(overrun)
  );

  result_uart_reporter dut_def (
    .clk(clk), .rst_n(rst_n), .report_valid(d_valid), .report_ready(d_ready),
    .mode(mode), .pass_vec(pass_vec), .fail_vec(fail_vec), .pass(pass), .fail(fail),
    .tx(d_tx), .busy(d_busy), .done(d_done), .overrun(d_overrun)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0][7:0] ref_pkt(input logic [2:0] m, input logic p, input logic f,
                                              input logic [5:0] pv, input logic [5:0] fv);
    logic [4:0][7:0] b;
    b[0] = 8'hA5;
    b[1] = {m, 3'b000, p, f};
    b[2] = {2'b00, pv};
    b[3] = {2'b00, fv};
    b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
    return b;
  endfunction

  // Line level expected k cycles after the accept edge: 10-bit frames of CPB cycles each
  function automatic logic line_bit(input logic [4:0][7:0] b, input int k);
    int pos, byt, bi;
    pos = k / CPB;
    byt = pos / 10;
    bi  = pos % 10;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return b[byt][bi-1];
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.mode = 3'($urandom_range(0, 4));
    v.pass = 1'($urandom);
    v.fail = 1'($urandom);
    v.pv   = 6'($urandom);
    v.fv   = 6'($urandom);
    v.exp  = ref_pkt(v.mode, v.pass, v.fail, v.pv, v.fv);
    return v;
  endfunction

  task automatic drive_report(input vec_t v);
    report_valid = 1'b1;
    mode     = v.mode;
    pass     = v.pass;
    fail     = v.fail;
    pass_vec = v.pv;
    fail_vec = v.fv;
  endtask

  task automatic scramble_inputs();
    mode     = 3'($urandom);
    pass     = 1'($urandom);
    fail     = 1'($urandom);
    pass_vec = 6'($urandom);
    fail_vec = 6'($urandom);
  endtask

  // Called #1 after an edge with the report already driven; the next edge is the accept edge.
  task automatic check_packet(input vec_t v, input string nm, input int ovr_at,
                              input bit chain, input vec_t nxt);
    int errs;
    int first;
    logic [4:0][7:0] dec;
    errs  = 0;
    first = -1;
    dec   = '0;
    @(posedge clk); #1;
    report_valid = 1'b0;
    for (int k = 0; k < PKT_CYC; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (tx !== line_bit(v.exp, k) || busy !== 1'b1 || done !== 1'b0 || report_ready !== 1'b0) begin
        errs++;
        if (first < 0) first = k;
      end
      if ((k % CPB) == CPB / 2 && ((k / CPB) % 10) >= 1 && ((k / CPB) % 10) <= 8)
        dec[(k / CPB) / 10][((k / CPB) % 10) - 1] = tx;
      scramble_inputs();
      report_valid = (k == ovr_at);
      if (k == ovr_at) exp_ovr = 1'b1;
    end
    report_valid = 1'b0;
    check({nm, "_bytes"}, dec, v.exp);
    check({nm, "_wave_errs"}, errs, 0);
    if (errs != 0) $display("  first bad cycle after accept for %s: %0d", nm, first);
    @(posedge clk); #1;
    check({nm, "_done_busy_ready_tx"}, {done, busy, report_ready, tx}, 4'b1011);
    check({nm, "_overrun"}, overrun, exp_ovr);
    if (chain) begin
      drive_report(nxt);
    end else begin
      @(posedge clk); #1;
      check({nm, "_done_one_cycle"}, {done, tx}, 2'b01);
    end
  endtask

  vec_t tbl[6];
  vec_t vo, vn, vr, vc, dummy;
  int   w, t, errs;

  initial begin
    // Spec-given vectors with hand-computed bytes, then random ones from the model
    tbl[0] = '{mode: MODE_2IN, pass: 1'b1, fail: 1'b0, pv: 6'h0F, fv: 6'h00,
               exp: {8'h88, 8'h00, 8'h0F, 8'h22, 8'hA5}};
    tbl[1] = '{mode: MODE_NOT, pass: 1'b0, fail: 1'b1, pv: 6'h3B, fv: 6'h04,
               exp: {8'h9B, 8'h04, 8'h3B, 8'h01, 8'hA5}};
    for (int i = 2; i < 6; i++) tbl[i] = rand_vec();
    dummy = tbl[0];

    rst_n   = 1'b0;
    d_valid = 1'b0;
    drive_report(tbl[0]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_outputs", {tx, busy, report_ready, done, overrun}, 5'b10100);
    end
    rst_n        = 1'b1;
    report_valid = 1'b0;
    errs = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("idle_after_reset", errs, 0);

    for (int i = 0; i < 6; i++) begin
      drive_report(tbl[i]);
      check_packet(tbl[i], $sformatf("vec%0d", i), -1, 1'b0, dummy);
    end

    // Overrun mid-packet, then a report in the done cycle chained straight on
    vo = tbl[1];
    vn = rand_vec();
    drive_report(vo);
    check_packet(vo, "overrun_pkt", 100, 1'b1, vn);
    check_packet(vn, "chained_pkt", -1, 1'b0, dummy);

    // Reset during B2 data bits
    vr = rand_vec();
    drive_report(vr);
    @(posedge clk); #1;
    report_valid = 1'b0;
    repeat (230) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_outputs", {tx, busy, report_ready, done, overrun}, 5'b10100);
    rst_n   = 1'b1;
    exp_ovr = 1'b0;
    errs = 0;
    repeat (600) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("midreset_quiet", errs, 0);
    vc = rand_vec();
    drive_report(vc);
    check_packet(vc, "post_reset_pkt", -1, 1'b0, dummy);

    // Default parameters: 434 clocks per bit
    @(negedge clk);
    mode = MODE_8IN; pass = 1'b1; fail = 1'b0; pass_vec = 6'h3F; fail_vec = 6'h00;
    d_valid = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    w = 0;
    while (d_tx === 1'b0 && w < 1000) begin
      w++;
      @(posedge clk); #1;
    end
    check("default_start_width", w, 434);
    t = w;
    while (d_done !== 1'b1 && t < 22000) begin
      @(posedge clk); #1;
      t++;
    end
    check("default_done_cycle", t, 21700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
